// File: rtl/bist_pattern_source.sv
// Purpose : BIST stimulus source; exhaustive-count or LFSR patterns over valid/ready, optional MISR compaction.
// Latency : first pattern valid 1 cycle after start; done rises the cycle after the last transfer.
// Backpr. : pat_ready low stalls indefinitely with pat_out/pat_cnt held; no pattern is dropped.
//
// Optional feature macro: PATGEN_MISR_EN (response MISR compaction into signature).
//
// Ports:
//   clk, rst              single clock, synchronous active-high reset
//   start, mode, num_pat  run request; mode/num_pat latched when start is accepted (IDLE/DONE)
//   pat_out, pat_valid    pattern to the gate under test, valid while running
//   pat_ready             consumer accepts pat_out this cycle
//   resp_in               same-cycle combinational response of the gate under test
//   busy, done            RUN / DONE state flags
//   pat_cnt               patterns accepted in the current/last run (saturating)
//   signature             MISR value, constant 0 when PATGEN_MISR_EN is undefined

module bist_pattern_source #(
    parameter int               PAT_W     = 2,
    parameter int               CNT_W     = 16,
    parameter logic [PAT_W-1:0] LFSR_TAPS = PAT_W'(2'b11),
    parameter logic [PAT_W-1:0] LFSR_SEED = PAT_W'(2'b01),
    parameter int               RESP_W    = 1,
    parameter int               SIG_W     = 16,
    parameter logic [SIG_W-1:0] SIG_TAPS  = SIG_W'(16'h8016)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [CNT_W-1:0]  num_pat,
    output logic [PAT_W-1:0]  pat_out,
    output logic              pat_valid,
    input  logic              pat_ready,
    input  logic [RESP_W-1:0] resp_in,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  pat_cnt,
    output logic [SIG_W-1:0]  signature
);

    // An all-zero seed would lock the LFSR at zero, so it is replaced by 1.
    localparam logic [PAT_W-1:0] SEED_NZ =
        (LFSR_SEED == '0) ? PAT_W'(1) : LFSR_SEED;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state;
    logic               mode_q;
    logic [CNT_W-1:0]   num_q;
    logic [PAT_W-1:0]   pat_next;
    logic [CNT_W-1:0]   cnt_next;
    logic               xfer;
    logic               start_go;

    assign xfer     = pat_valid && pat_ready;
    // start is only honoured outside RUN.
    assign start_go = start && (state != S_RUN);

    always_comb begin
        pat_next = pat_out + 1'b1;
        if (mode_q) begin
            pat_next = {pat_out[PAT_W-2:0], ^(pat_out & LFSR_TAPS)};
        end
    end

    // Saturate rather than wrap.
    assign cnt_next = (&pat_cnt) ? pat_cnt : pat_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            mode_q    <= 1'b0;
            num_q     <= '0;
            pat_out   <= '0;
            pat_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pat_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_go) begin
                        mode_q  <= mode;
                        num_q   <= num_pat;
                        pat_cnt <= '0;
                        pat_out <= mode ? SEED_NZ : '0;
                        if (num_pat == '0) begin
                            // Empty run: straight to DONE, valid never rises.
                            state     <= S_DONE;
                            pat_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            state     <= S_RUN;
                            pat_valid <= 1'b1;
                            busy      <= 1'b1;
                            done      <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    if (xfer) begin
                        pat_cnt <= cnt_next;
                        pat_out <= pat_next;
                        if (cnt_next == num_q) begin
                            state     <= S_DONE;
                            pat_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    pat_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

`ifdef PATGEN_MISR_EN
    logic [SIG_W-1:0] sig_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= '0;
        end else if (start_go) begin
            sig_q <= '0;
        end else if (xfer && (state == S_RUN)) begin
            sig_q <= {sig_q[SIG_W-2:0], ^(sig_q & SIG_TAPS)} ^ SIG_W'(resp_in);
        end
    end

    assign signature = sig_q;
`else
    // Response is not compacted in this build.
    logic unused_resp;
    assign unused_resp = ^resp_in;
    assign signature   = '0;
`endif

endmodule

// File: tb/tb_bist_pattern_source.sv
// Purpose : directed self-checking bench for bist_pattern_source (PAT_W=2, SIG_W=4).
// Latency : inputs driven and outputs sampled 1 ns after each rising edge.
// Backpr. : pat_ready driven directly by the stimulus sequence.

module tb_bist_pattern_source;

`ifdef PATGEN_MISR_EN
    localparam bit MISR_ON = 1'b1;
`else
    localparam bit MISR_ON = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic        mode;
    logic [15:0] num_pat;
    logic [1:0]  pat_out;
    logic        pat_valid;
    logic        pat_ready;
    logic [0:0]  resp_in;
    logic        busy;
    logic        done;
    logic [15:0] pat_cnt;
    logic [3:0]  signature;

    logic [1:0]  d0_pat_out;
    logic        unused_d0_valid;
    logic        unused_d0_busy;
    logic        unused_d0_done;
    logic [15:0] unused_d0_cnt;
    logic [3:0]  unused_d0_sig;

    int checks = 0;
    int errors = 0;

    bist_pattern_source #(
        .PAT_W(2), .CNT_W(16), .LFSR_TAPS(2'b11), .LFSR_SEED(2'b01),
        .RESP_W(1), .SIG_W(4), .SIG_TAPS(4'b1001)
    ) u_dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .num_pat(num_pat),
        .pat_out(pat_out), .pat_valid(pat_valid), .pat_ready(pat_ready),
        .resp_in(resp_in), .busy(busy), .done(done), .pat_cnt(pat_cnt),
        .signature(signature)
    );

    // Zero seed instance: must start its LFSR run from 01.
    bist_pattern_source #(
        .PAT_W(2), .CNT_W(16), .LFSR_TAPS(2'b11), .LFSR_SEED(2'b00),
        .RESP_W(1), .SIG_W(4), .SIG_TAPS(4'b1001)
    ) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .num_pat(num_pat),
        .pat_out(d0_pat_out), .pat_valid(unused_d0_valid), .pat_ready(pat_ready),
        .resp_in(resp_in), .busy(unused_d0_busy), .done(unused_d0_done),
        .pat_cnt(unused_d0_cnt), .signature(unused_d0_sig)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [1:0] exp_seq2 [6];
    logic [1:0] exp_lfsr [4];
    logic [3:0] exp_sig  [3];

    initial begin
        exp_seq2 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        exp_lfsr = '{2'b01, 2'b11, 2'b10, 2'b01};
        exp_sig  = '{4'h1, 4'h2, 4'h5};

        rst = 1'b1; start = 1'b0; mode = 1'b0; num_pat = 16'd0;
        pat_ready = 1'b0; resp_in = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_pat_out",   32'(pat_out),   32'd0);
        chk("rst_valid",     32'(pat_valid), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_done",      32'(done),      32'd0);
        chk("rst_cnt",       32'(pat_cnt),   32'd0);
        chk("rst_signature", 32'(signature), 32'd0);
        rst = 1'b0;
        tick();

        // 1: exhaustive, 4 patterns, ready high
        start = 1'b1; mode = 1'b0; num_pat = 16'd4; pat_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t1_pat", 32'(pat_out), 32'(i));
            chk("t1_valid", 32'(pat_valid), 32'd1);
            tick();
        end
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_cnt", 32'(pat_cnt), 32'd4);
        chk("t1_valid_low", 32'(pat_valid), 32'd0);
        chk("t1_busy_low", 32'(busy), 32'd0);

        // 2: restart from DONE, 6 patterns with wrap
        start = 1'b1; mode = 1'b0; num_pat = 16'd6;
        tick();
        start = 1'b0;
        chk("t2_done_drop", 32'(done), 32'd0);
        for (int i = 0; i < 6; i++) begin
            chk("t2_pat", 32'(pat_out), 32'(exp_seq2[i]));
            tick();
        end
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_cnt", 32'(pat_cnt), 32'd6);

        // 3: LFSR, 4 patterns; zero-seed instance starts at 01
        start = 1'b1; mode = 1'b1; num_pat = 16'd4;
        tick();
        start = 1'b0;
        chk("t3_seed0_first", 32'(d0_pat_out), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("t3_lfsr", 32'(pat_out), 32'(exp_lfsr[i]));
            tick();
        end
        chk("t3_done", 32'(done), 32'd1);
        chk("t3_cnt", 32'(pat_cnt), 32'd4);

        // 4: 3-cycle stall after the 2nd pattern is presented
        start = 1'b1; mode = 1'b0; num_pat = 16'd4;
        tick();
        start = 1'b0;
        chk("t4_first", 32'(pat_out), 32'd0);
        tick();
        pat_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_stall_pat", 32'(pat_out), 32'd1);
            chk("t4_stall_cnt", 32'(pat_cnt), 32'd1);
            chk("t4_stall_valid", 32'(pat_valid), 32'd1);
        end
        pat_ready = 1'b1;
        tick();
        tick();
        chk("t4_last_pat", 32'(pat_out), 32'd3);
        chk("t4_not_done", 32'(done), 32'd0);
        tick();
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_cnt", 32'(pat_cnt), 32'd4);

        // 4b: empty run
        start = 1'b1; num_pat = 16'd0;
        tick();
        start = 1'b0;
        chk("t4b_done", 32'(done), 32'd1);
        chk("t4b_valid", 32'(pat_valid), 32'd0);
        chk("t4b_cnt", 32'(pat_cnt), 32'd0);
        tick();
        chk("t4b_valid_hold", 32'(pat_valid), 32'd0);

        // 5: start ignored in RUN, then reset mid-run
        start = 1'b1; mode = 1'b0; num_pat = 16'd4;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; mode = 1'b1; num_pat = 16'd1;
        tick();
        start = 1'b0;
        chk("t5_ign_cnt", 32'(pat_cnt), 32'd2);
        chk("t5_ign_pat", 32'(pat_out), 32'd2);
        chk("t5_ign_busy", 32'(busy), 32'd1);
        rst = 1'b1; start = 1'b1; num_pat = 16'd4;
        tick();
        chk("t5_rst_pat", 32'(pat_out), 32'd0);
        chk("t5_rst_valid", 32'(pat_valid), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_done", 32'(done), 32'd0);
        chk("t5_rst_cnt", 32'(pat_cnt), 32'd0);
        rst = 1'b0; start = 1'b0;
        tick();
        chk("t5_idle_done", 32'(done), 32'd0);
        chk("t5_idle_valid", 32'(pat_valid), 32'd0);

        // 6: signature over 3 transfers with resp_in=1
        start = 1'b1; mode = 1'b0; num_pat = 16'd3; resp_in = 1'b1;
        tick();
        start = 1'b0;
        chk("t6_sig_clr", 32'(signature), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_sig", 32'(signature), MISR_ON ? 32'(exp_sig[i]) : 32'd0);
        end
        chk("t6_done", 32'(done), 32'd1);
        tick();
        chk("t6_sig_hold", 32'(signature), MISR_ON ? 32'h5 : 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
